// File: rtl/wb_uart_rx_slave.sv
// wb_uart_rx_slave: Wishbone classic slave with 8N1 UART receiver and RX FIFO
`timescale 1ns/1ps
module wb_uart_rx_slave #(
  parameter logic [15:0] DIVISOR_RST = 16'd54,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          FIFO_AW     = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  output logic       wb_ack_o,
  output logic       wb_err_o,
  input  logic       srx_pad_i,
  output logic       int_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t             state_q, state_d;
  logic               ack_q, ack_d, err_q, err_d, we_q, we_d;
  logic [2:0]         adr_q, adr_d;
  logic [7:0]         wdat_q, wdat_d;
  logic [15:0]        div_q, div_d, cnt_q, cnt_d;
  logic               rx_en_q, rx_en_d, int_en_q, int_en_d;
  logic [1:0]         sync_q, sync_d;
  logic [3:0]         sc_q, sc_d;
  logic [2:0]         bc_q, bc_d;
  logic [7:0]         sh_q, sh_d;
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               oe_q, oe_d, fe_q, fe_d, int_q, int_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic               req, wr, rd_rbr, rd_stat, flush, rxs, tick;
  logic               push, fe_set, push_en, oe_set, pop, full, dr;
  logic [7:0]         stat, rdata;
  always_comb begin
    req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    ack_d    = req & (wb_adr_i < 3'd5);
    err_d    = req & (wb_adr_i >= 3'd5);
    adr_d    = req ? wb_adr_i : adr_q;
    we_d     = req ? wb_we_i : we_q;
    wdat_d   = req ? wb_dat_i : wdat_q;
    wr       = ack_q & we_q;
    rd_rbr   = ack_q & ~we_q & (adr_q == 3'd0);
    rd_stat  = ack_q & ~we_q & (adr_q == 3'd1);
    flush    = wr & (adr_q == 3'd4) & wdat_q[2];
    div_d    = {(wr && adr_q == 3'd3) ? wdat_q : div_q[15:8],
                (wr && adr_q == 3'd2) ? wdat_q : div_q[7:0]};
    rx_en_d  = (wr && adr_q == 3'd4) ? wdat_q[0] : rx_en_q;
    int_en_d = (wr && adr_q == 3'd4) ? wdat_q[1] : int_en_q;
    sync_d   = {sync_q[0], srx_pad_i};
    rxs      = sync_q[1];
    tick     = (cnt_q == 16'd0);
    cnt_d    = tick ? ((div_q == 16'd0) ? 16'd0 : div_q - 16'd1) : cnt_q - 16'd1;
    state_d  = state_q;
    sc_d     = sc_q;
    bc_d     = bc_q;
    sh_d     = sh_q;
    push     = 1'b0;
    fe_set   = 1'b0;
    case (state_q)
      IDLE: if (!rxs) begin
        state_d = START;
        sc_d    = 4'd0;
      end
      START: if (tick) begin
        sc_d = sc_q + 4'd1;
        if (sc_q == 4'd7) begin
          state_d = rxs ? IDLE : DATA;
          sc_d    = 4'd0;
          bc_d    = 3'd0;
        end
      end
      DATA: if (tick) begin
        sc_d = sc_q + 4'd1;
        if (sc_q == 4'd15) begin
          sh_d    = {rxs, sh_q[7:1]};
          bc_d    = bc_q + 3'd1;
          state_d = (bc_q == 3'd7) ? STOP : DATA;
        end
      end
      STOP: if (tick) begin
        sc_d = sc_q + 4'd1;
        if (sc_q == 4'd15) begin
          push    = rxs;
          fe_set  = ~rxs;
          state_d = rxs ? IDLE : BRK;
        end
      end
      BRK: state_d = rxs ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
    if (!rx_en_q) begin
      state_d = IDLE;
      push    = 1'b0;
      fe_set  = 1'b0;
    end
    full    = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    dr      = (count_q != '0);
    pop     = rd_rbr & dr;
    push_en = push & ~flush & (~full | pop);
    oe_set  = push & ~flush & full & ~pop;
    wp_d    = flush ? '0 : wp_q + FIFO_AW'(push_en);
    rp_d    = flush ? '0 : rp_q + FIFO_AW'(pop);
    count_d = flush ? '0 : count_q + (FIFO_AW+1)'(push_en) - (FIFO_AW+1)'(pop);
    oe_d    = oe_set | (oe_q & ~rd_stat);
    fe_d    = fe_set | (fe_q & ~rd_stat);
    int_d   = int_en_q & (dr | oe_q | fe_q);
    stat    = {4'b0, full, fe_q, oe_q, dr};
    rdata   = (adr_q == 3'd0) ? (dr ? mem_q[rp_q] : 8'h00) :
              (adr_q == 3'd1) ? stat :
              (adr_q == 3'd2) ? div_q[7:0] :
              (adr_q == 3'd3) ? div_q[15:8] :
              (adr_q == 3'd4) ? {6'b0, int_en_q, rx_en_q} : 8'h00;
    wb_dat_o = ack_q ? rdata : 8'h00;
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 3'd0;
      wdat_q   <= 8'h00;
      div_q    <= DIVISOR_RST;
      cnt_q    <= DIVISOR_RST - 16'd1;
      rx_en_q  <= 1'b1;
      int_en_q <= 1'b0;
      sync_q   <= 2'b11;
      state_q  <= IDLE;
      sc_q     <= 4'd0;
      bc_q     <= 3'd0;
      sh_q     <= 8'h00;
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      oe_q     <= 1'b0;
      fe_q     <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      rx_en_q  <= rx_en_d;
      int_en_q <= int_en_d;
      sync_q   <= sync_d;
      state_q  <= state_d;
      sc_q     <= sc_d;
      bc_q     <= bc_d;
      sh_q     <= sh_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      oe_q     <= oe_d;
      fe_q     <= fe_d;
      int_q    <= int_d;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_ni && push_en) mem_q[wp_q] <= sh_q;
  end
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign int_o    = int_q;
endmodule
